// File: rtl/cpx_multiply_axis_pkg.sv
// Shared helpers for the complex multiplier slice.
package cpx_multiply_axis_pkg;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpx_multiply_axis_signed_mult_reg.sv
// Registered full-precision signed multiply with clock enable and async reset.
module signed_mult_reg #(
    parameter int a_bits = 12,
    parameter int b_bits = 12,
    parameter int p_bits = a_bits + b_bits
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [a_bits-1:0] a,
    input  logic signed [b_bits-1:0] b,
    output logic signed [p_bits-1:0] p
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= p_bits'(a) * p_bits'(b);
        end
    end

endmodule

// File: rtl/cpx_multiply_axis.sv
// Two-stage pipelined signed complex multiplier with valid/ready stream handshake.
module cpx_multiply_axis
    import cpx_multiply_axis_pkg::*;
#(
    parameter int xi_bits = 12,
    parameter int xq_bits = 12,
    parameter int yi_bits = 12,
    parameter int yq_bits = 12,
    parameter int i_bits  = 24,
    parameter int q_bits  = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m_axis_tvalid,
    input  logic signed [xi_bits-1:0] xi,
    input  logic signed [xq_bits-1:0] xq,
    input  logic signed [yi_bits-1:0] yi,
    input  logic signed [yq_bits-1:0] yq,
    input  logic                      m_axis_tready,
    output logic                      s_axis_tready,
    output logic                      s_axis_tvalid,
    output logic signed [i_bits-1:0]  i,
    output logic signed [q_bits-1:0]  q
);

    localparam int I_W = max_int(xi_bits + yi_bits, xq_bits + yq_bits) + 1;
    localparam int Q_W = max_int(xi_bits + yq_bits, xq_bits + yi_bits) + 1;

    logic signed [xi_bits+yi_bits-1:0] p_ii;
    logic signed [xq_bits+yq_bits-1:0] p_qq;
    logic signed [xi_bits+yq_bits-1:0] p_iq;
    logic signed [xq_bits+yi_bits-1:0] p_qi;
    logic                              valid1;

    logic signed [I_W-1:0]    i_sum;
    logic signed [Q_W-1:0]    q_sum;
    logic signed [i_bits-1:0] i_fit;
    logic signed [q_bits-1:0] q_fit;

    assign s_axis_tready = m_axis_tready;

    signed_mult_reg #(.a_bits(xi_bits), .b_bits(yi_bits)) u_mul_ii (
        .clk(clk), .rst_n(rst_n), .en(m_axis_tready), .a(xi), .b(yi), .p(p_ii)
    );
    signed_mult_reg #(.a_bits(xq_bits), .b_bits(yq_bits)) u_mul_qq (
        .clk(clk), .rst_n(rst_n), .en(m_axis_tready), .a(xq), .b(yq), .p(p_qq)
    );
    signed_mult_reg #(.a_bits(xi_bits), .b_bits(yq_bits)) u_mul_iq (
        .clk(clk), .rst_n(rst_n), .en(m_axis_tready), .a(xi), .b(yq), .p(p_iq)
    );
    signed_mult_reg #(.a_bits(xq_bits), .b_bits(yi_bits)) u_mul_qi (
        .clk(clk), .rst_n(rst_n), .en(m_axis_tready), .a(xq), .b(yi), .p(p_qi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1 <= 1'b0;
        end else if (m_axis_tready) begin
            valid1 <= m_axis_tvalid;
        end
    end

    assign i_sum = I_W'(p_ii) - I_W'(p_qq);
    assign q_sum = Q_W'(p_iq) + Q_W'(p_qi);

    // Signed size cast sign-extends when the output is wider and wraps to the low bits otherwise.
    assign i_fit = i_bits'(i_sum);
    assign q_fit = q_bits'(q_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i             <= '0;
            q             <= '0;
            s_axis_tvalid <= 1'b0;
        end else if (m_axis_tready) begin
            i             <= i_fit;
            q             <= q_fit;
            s_axis_tvalid <= valid1;
        end
    end

endmodule

// File: tb/tb_cpx_multiply_axis.sv
// Scoreboard bench for cpx_multiply_axis with default 12-bit operands, 24-bit results.
module tb_cpx_multiply_axis;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                m_axis_tvalid;
    logic signed [11:0]  xi, xq, yi, yq;
    logic                m_axis_tready;
    logic                s_axis_tready;
    logic                s_axis_tvalid;
    logic signed [23:0]  i, q;

    typedef struct packed {
        logic              v;
        logic signed [23:0] ei;
        logic signed [23:0] eq;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cpx_multiply_axis #(
        .xi_bits(12), .xq_bits(12), .yi_bits(12), .yq_bits(12),
        .i_bits(24), .q_bits(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_axis_tvalid(m_axis_tvalid),
        .xi(xi), .xq(xq), .yi(yi), .yq(yq),
        .m_axis_tready(m_axis_tready), .s_axis_tready(s_axis_tready),
        .s_axis_tvalid(s_axis_tvalid), .i(i), .q(q)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic v, input logic signed [11:0] a, input logic signed [11:0] b,
                                   input logic signed [11:0] c, input logic signed [11:0] d);
        exp_t   e;
        longint fi, fq;
        fi   = longint'(a) * longint'(c) - longint'(b) * longint'(d);
        fq   = longint'(a) * longint'(d) + longint'(b) * longint'(c);
        e.v  = v;
        e.ei = fi[23:0];
        e.eq = fq[23:0];
        return e;
    endfunction

    task automatic check_cur(input string tag);
        check({tag, "_valid"}, longint'(s_axis_tvalid), longint'(cur.v));
        check({tag, "_i"}, longint'(i), longint'(cur.ei));
        check({tag, "_q"}, longint'(q), longint'(cur.eq));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic tv, input logic tr, input logic signed [11:0] a,
                        input logic signed [11:0] b, input logic signed [11:0] c,
                        input logic signed [11:0] d, input string tag);
        m_axis_tvalid = tv;
        m_axis_tready = tr;
        xi = a; xq = b; yi = c; yq = d;
        #1;
        check({tag, "_s_tready"}, longint'(s_axis_tready), longint'(tr));
        @(posedge clk);
        #1;
        if (tr) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 1, 0);
            end else begin
                cur = sb.pop_front();
            end
            sb.push_back(model(tv, a, b, c, d));
        end
        check_cur(tag);
        @(negedge clk);
    endtask

    task automatic rand_step(input logic tv, input logic tr, input string tag);
        logic signed [11:0] a, b, c, d;
        a = 12'($urandom); b = 12'($urandom);
        c = 12'($urandom); d = 12'($urandom);
        step(tv, tr, a, b, c, d, tag);
    endtask

    task automatic restart_scoreboard();
        sb.delete();
        sb.push_back('0);
        cur = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        m_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0;
        #1;
        check("rst_valid", longint'(s_axis_tvalid), 0);
        check("rst_i", longint'(i), 0);
        check("rst_q", longint'(q), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        restart_scoreboard();

        // Basic product, then bubbles so the valid pulse is exactly one cycle.
        step(1, 1, 12'sd3, 12'sd4, 12'sd5, -12'sd2, "basic_in");
        step(0, 1, '0, '0, '0, '0, "basic_b0");
        check("basic_i_const", longint'(i), 23);
        check("basic_q_const", longint'(q), 14);
        check("basic_v_const", longint'(s_axis_tvalid), 1);
        step(0, 1, '0, '0, '0, '0, "basic_b1");
        check("basic_pulse_end", longint'(s_axis_tvalid), 0);

        for (int k = 0; k < 8; k++) rand_step(1, 1, "stream");

        for (int k = 0; k < 3; k++) rand_step(1, 1, "bp_pre");
        for (int k = 0; k < 3; k++) rand_step(1, 0, "bp_hold");
        for (int k = 0; k < 4; k++) rand_step(1, 1, "bp_post");

        step(1, 1, -12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, "ext_in");
        step(0, 1, '0, '0, '0, '0, "ext_b0");
        check("ext_i_const", longint'(i), 0);
        check("ext_q_const", longint'(q), -8388608);
        step(1, 1, 12'sd2047, -12'sd2048, 12'sd2047, 12'sd2047, "ext2_in");
        step(1, 1, -12'sd2048, 12'sd2047, 12'sd2047, -12'sd2048, "ext3_in");

        for (int k = 0; k < 8; k++) rand_step(logic'(k % 2 == 0), 1, "bubble");
        step(0, 1, '0, '0, '0, '0, "bubble_d0");
        step(0, 1, '0, '0, '0, '0, "bubble_d1");

        // Mid-cycle asynchronous reset with two operand sets in flight.
        rand_step(1, 1, "rst_pre0");
        rand_step(1, 1, "rst_pre1");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", longint'(s_axis_tvalid), 0);
        check("arst_i", longint'(i), 0);
        check("arst_q", longint'(q), 0);
        m_axis_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        restart_scoreboard();
        for (int k = 0; k < 3; k++) step(0, 1, '0, '0, '0, '0, "post_rst");
        for (int k = 0; k < 4; k++) rand_step(1, 1, "post_rst_stream");
        for (int k = 0; k < 2; k++) step(0, 1, '0, '0, '0, '0, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
